// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared register-file geometry and scoreboard state encoding
package core_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 6;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  typedef enum logic {
    SB_RUN,
    SB_DRAIN
  } sb_state_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// rtl/issue_scoreboard_if.sv - decode issue and writeback signals seen by the scoreboard
interface issue_scoreboard_if;
  import core_pkg::*;

  logic     issue_valid;
  reg_idx_t issue_rs1;
  reg_idx_t issue_rs2;
  logic     issue_uses_rs1;
  logic     issue_uses_rs2;
  reg_idx_t issue_rd;
  logic     issue_writes_rd;
  logic     issue_ready;
  logic     wb_valid;
  reg_idx_t wb_rd;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_uses_rs1, issue_uses_rs2,
    output issue_rd, issue_writes_rd, wb_valid, wb_rd,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_uses_rs1, issue_uses_rs2,
    input  issue_rd, issue_writes_rd, wb_valid, wb_rd,
    output issue_ready
  );

endinterface

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - RAW/WAW issue scoreboard with flush-drain sequencing
module issue_scoreboard
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  issue_scoreboard_if.slave  sb,
  input  logic               flush_req,
  output logic               drained,
  output logic [CNT_W-1:0]   busy_count,
  output logic               wb_err
);

  logic [NUM_REGS-1:0] r_busy;
  logic [CNT_W-1:0]    r_busy_count;
  sb_state_t           r_state;
  logic                r_wb_err;
  logic                r_drained;

  logic                w_clr;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_busy_eff;
  logic                w_hazard;
  logic                w_fire;
  logic                w_set;
  logic                w_eff_clr;
  logic                w_stray_wb;

  // Writeback in this cycle releases its register immediately; the regfile
  // writes before it reads, so the dependent instruction sees fresh data.
  assign w_clr      = sb.wb_valid && (sb.wb_rd != '0);
  assign w_clr_mask = w_clr ? (NUM_REGS'(1) << sb.wb_rd) : '0;
  assign w_busy_eff = r_busy & ~w_clr_mask;

  assign w_hazard = (sb.issue_uses_rs1  && w_busy_eff[sb.issue_rs1]) ||
                    (sb.issue_uses_rs2  && w_busy_eff[sb.issue_rs2]) ||
                    (sb.issue_writes_rd && w_busy_eff[sb.issue_rd]);

  assign sb.issue_ready = (r_state == SB_RUN) && !w_hazard;

  assign w_fire     = sb.issue_valid && sb.issue_ready;
  assign w_set      = w_fire && sb.issue_writes_rd && (sb.issue_rd != '0);
  assign w_set_mask = w_set ? (NUM_REGS'(1) << sb.issue_rd) : '0;
  assign w_eff_clr  = w_clr && r_busy[sb.wb_rd];
  assign w_stray_wb = w_clr && !r_busy[sb.wb_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy       <= '0;
      r_busy_count <= '0;
      r_state      <= SB_RUN;
      r_wb_err     <= 1'b0;
      r_drained    <= 1'b0;
    end else begin
      // OR-ing the set mask last lets a same-register set win over its clear.
      r_busy <= w_busy_eff | w_set_mask;

      if (w_set && !w_eff_clr) begin
        r_busy_count <= r_busy_count + CNT_W'(1);
      end else if (w_eff_clr && !w_set) begin
        r_busy_count <= r_busy_count - CNT_W'(1);
      end

      if (w_stray_wb) begin
        r_wb_err <= 1'b1;
      end

      r_drained <= 1'b0;
      case (r_state)
        SB_RUN: begin
          if (flush_req) begin
            r_state <= SB_DRAIN;
          end
        end
        SB_DRAIN: begin
          if (r_busy_count == '0) begin
            r_state   <= SB_RUN;
            r_drained <= 1'b1;
          end
        end
        default: r_state <= SB_RUN;
      endcase
    end
  end

  assign busy_count = r_busy_count;
  assign wb_err     = r_wb_err;
  assign drained    = r_drained;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - self-checking bench for issue_scoreboard
module tb_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_req;
  logic       drained;
  logic [5:0] busy_count;
  logic       wb_err;

  int n_checks = 0;
  int n_fail   = 0;

  issue_scoreboard_if sbif ();

  issue_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .sb         (sbif.slave),
    .flush_req  (flush_req),
    .drained    (drained),
    .busy_count (busy_count),
    .wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  // Reference: a plain array of busy flags; the count is derived by counting.
  bit m_busy[32];
  bit m_drain;
  bit m_err;
  bit m_drained;
  bit pre_ready;
  bit m_pre_ready;

  function automatic int m_pop();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  function automatic bit m_eff(int r);
    bit released = sbif.wb_valid && (sbif.wb_rd != 0) && (int'(sbif.wb_rd) == r);
    return m_busy[r] && !released;
  endfunction

  function automatic bit m_ready();
    bit hz;
    if (m_drain) return 1'b0;
    hz = (sbif.issue_uses_rs1  && m_eff(int'(sbif.issue_rs1))) ||
         (sbif.issue_uses_rs2  && m_eff(int'(sbif.issue_rs2))) ||
         (sbif.issue_writes_rd && m_eff(int'(sbif.issue_rd)));
    return !hz;
  endfunction

  task automatic m_update();
    bit fire, was_drain, idle;
    if (rst) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      m_drain = 1'b0; m_err = 1'b0; m_drained = 1'b0;
      return;
    end
    fire      = sbif.issue_valid && m_ready();
    was_drain = m_drain;
    idle      = (m_pop() == 0);
    if (sbif.wb_valid && sbif.wb_rd != 0) begin
      if (m_busy[sbif.wb_rd]) m_busy[sbif.wb_rd] = 1'b0;
      else m_err = 1'b1;
    end
    if (fire && sbif.issue_writes_rd && sbif.issue_rd != 0) m_busy[sbif.issue_rd] = 1'b1;
    m_drained = was_drain && idle;
    if (!was_drain && flush_req) m_drain = 1'b1;
    else if (was_drain && idle) m_drain = 1'b0;
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wr,
                       bit wbv, int wbrd, bit fl);
    sbif.issue_valid     = v;
    sbif.issue_rs1       = 5'(rs1);
    sbif.issue_uses_rs1  = u1;
    sbif.issue_rs2       = 5'(rs2);
    sbif.issue_uses_rs2  = u2;
    sbif.issue_rd        = 5'(rd);
    sbif.issue_writes_rd = wr;
    sbif.wb_valid        = wbv;
    sbif.wb_rd           = 5'(wbrd);
    flush_req            = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Inputs are already applied; sample combinational ready mid-cycle, then
  // clock the DUT and model together and leave time 1 past the edge.
  task automatic do_cycle();
    #2;
    pre_ready   = sbif.issue_ready;
    m_pre_ready = m_ready();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    do_cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    bit v; int rs1; bit u1; int rs2; bit u2; int rd; bit wr; bit wbv; int wbrd;
    bit exp_ready; int exp_count; bit exp_err;
  } vec_t;

  vec_t tbl[11];
  int   pulses;

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    do_reset();
    check("reset_count", int'(busy_count), 0);
    check("reset_err", int'(wb_err), 0);
    check("reset_drained", int'(drained), 0);

    //           v rs1 u1 rs2 u2 rd wr wbv wbrd rdy cnt err
    tbl[0]  = '{1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 1, 0};
    tbl[1]  = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{1, 5, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0};
    tbl[3]  = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 7, 1, 1, 7, 1, 1, 0};
    tbl[6]  = '{0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 1, 1};
    tbl[9]  = '{0, 0, 0, 7, 1, 0, 0, 1, 7, 1, 0, 1};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2,
            tbl[i].rd, tbl[i].wr, tbl[i].wbv, tbl[i].wbrd, 0);
      do_cycle();
      check($sformatf("tbl%0d_ready", i), int'(pre_ready), int'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_count", i), int'(busy_count), tbl[i].exp_count);
      check($sformatf("tbl%0d_err", i), int'(wb_err), int'(tbl[i].exp_err));
    end

    // Flush with two outstanding writes, drained once both retire.
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); do_cycle();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); do_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); do_cycle();
    check("drain_flush_ready", int'(pre_ready), 1);
    drive(1, 1, 1, 0, 0, 0, 0, 1, 3, 1); do_cycle();
    check("drain_ready_wb3", int'(pre_ready), 0);
    check("drain_count_wb3", int'(busy_count), 1);
    drive(1, 1, 1, 0, 0, 0, 0, 1, 4, 0); do_cycle();
    check("drain_ready_wb4", int'(pre_ready), 0);
    check("drain_count_wb4", int'(busy_count), 0);
    check("drain_early_pulse", int'(drained), 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      do_cycle();
      pulses += int'(drained);
    end
    check("drain_pulses", pulses, 1);
    check("drain_run_ready", int'(pre_ready), 1);

    // Reset arriving mid-drain overrides a simultaneous set and writeback.
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); do_cycle();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); do_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); do_cycle();
    check("rstdrain_count_pre", int'(busy_count), 2);
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 5, 1, 1, 3, 1); do_cycle();
    rst = 1'b0;
    check("rstdrain_count", int'(busy_count), 0);
    check("rstdrain_drained", int'(drained), 0);
    drive(1, 3, 1, 4, 1, 5, 1, 0, 0, 0); do_cycle();
    check("rstdrain_ready", int'(pre_ready), 1);

    // Flush with nothing outstanding: one DRAIN cycle, then the pulse.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); do_cycle();
    check("empty_flush_ready", int'(pre_ready), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); do_cycle();
    check("empty_drain_ready", int'(pre_ready), 0);
    check("empty_drained", int'(drained), 1);
    idle(); do_cycle();
    check("empty_after_ready", int'(pre_ready), 1);
    check("empty_after_drained", int'(drained), 0);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 9) < 7,
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 29) == 0);
      do_cycle();
      check("rnd_ready", int'(pre_ready), int'(m_pre_ready));
      check("rnd_count", int'(busy_count), m_pop());
      check("rnd_err", int'(wb_err), int'(m_err));
      check("rnd_drained", int'(drained), int'(m_drained));
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameters SHALL be none; register count 32 and address width 5 SHALL come from the shared package.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 issue_valid  input  1  decode presents an instruction this cycle.
REQ-005 issue_rs1, issue_rs2  input  5 each  source register indices, matching the register file's read selects.
REQ-006 issue_uses_rs1, issue_uses_rs2  input  1 each  source operand actually read.
REQ-007 issue_rd  input  5  destination register index.
REQ-008 issue_writes_rd  input  1  instruction writes issue_rd.
REQ-009 issue_ready  output  1  instruction may issue this cycle.
REQ-010 wb_valid  input  1  a result is written to the register file this cycle.
REQ-011 wb_rd  input  5  register written, equal to the register file write select.
REQ-012 flush_req  input  1  single-cycle request to drain all outstanding writes.
REQ-013 drained  output  1  one-cycle pulse when a drain completes.
REQ-014 busy_count  output  6  number of registers with an outstanding write, 0..31.
REQ-015 wb_err  output  1  sticky flag for writeback to a non-busy register.

Function
REQ-016 State: busy[31:0], busy_count, FSM {RUN, DRAIN}, wb_err.
REQ-017 clr = wb_valid & wb_rd!=0; busy_eff = busy with bit wb_rd cleared when clr is true, in the same cycle.
REQ-018 hazard = (uses_rs1 & busy_eff[rs1]) | (uses_rs2 & busy_eff[rs2]) | (writes_rd & busy_eff[rd]), covering RAW and WAW.
REQ-019 issue_ready = (state==RUN) & ~hazard, combinational and independent of issue_valid.
REQ-020 fire = issue_valid & issue_ready; set = fire & writes_rd & rd!=0.
REQ-021 On set, busy[rd] SHALL be 1 on the next cycle.
REQ-022 On clr, busy[wb_rd] SHALL be 0 on the next cycle unless set targets the same register; set wins.
REQ-023 Register x0 SHALL never be busy; writes to or reads of x0 SHALL never stall.
REQ-024 busy_count SHALL go +1 on set only, -1 on an effective clr only, and be unchanged when both occur.
REQ-025 An effective clr requires busy[wb_rd]==1.
REQ-026 wb_valid to a non-busy nonzero register SHALL set wb_err; busy and busy_count SHALL be unchanged.
REQ-027 A writeback in cycle N SHALL release dependent issue in cycle N; the register file write-before-read guarantees the data.
REQ-028 RUN -> DRAIN on flush_req.
REQ-029 DRAIN -> RUN when busy_count==0, with drained=1 for that single cycle.
REQ-030 flush_req in DRAIN SHALL be ignored.
REQ-031 flush_req with busy_count already 0: DRAIN for one cycle, drained pulse in the next cycle.
REQ-032 In DRAIN, issue_ready=0 while writebacks continue to clear bits.

Reset
REQ-033 While rst=1 at posedge, the block SHALL reset to: busy=0, busy_count=0, state=RUN, wb_err=0, drained=0.
REQ-034 Reset SHALL override a simultaneous set, clr or flush_req, including reset during DRAIN.
REQ-035 issue_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-036 Shared package core_pkg SHALL hold NUM_REGS=32, REG_ADDR_W=5 and the enum sb_state_t {SB_RUN, SB_DRAIN}.
REQ-037 The block SHALL be a single module with no sub-module; busy_count SHALL be a counter, not a popcount.

Verification
REQ-038 Issue rd=5 -> busy_count=1; next issue rs1=5 -> issue_ready=0 until wb_rd=5, when issue_ready=1 in that same cycle.
REQ-039 Issue rd=0 -> busy stays 0 and busy_count=0; issue rs1=0, rs2=0 -> never stalls.
REQ-040 In the same cycle, wb_rd=7 (busy) and issue rd=7 -> busy[7]=1 and busy_count unchanged.
REQ-041 wb_rd=9 while not busy -> wb_err=1 and stays 1; busy_count unchanged.
REQ-042 Issue rd=3 and rd=4, then flush_req -> issue_ready=0; writebacks wb 3, wb 4 -> drained pulses exactly once and state returns to RUN.
REQ-043 rst asserted during DRAIN with busy_count=2 -> next cycle busy_count=0, issue_ready=1, drained=0.
